// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock via one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the ovf (two's-complement overflow) output.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             z;
  logic             d;
  logic             borrow_nxt;

  // Full-subtractor cell working on the current LSB of both operands.
  assign x          = a_sr[0];
  assign y          = b_sr[0];
  assign z          = borrow;
  assign d          = x ^ y ^ z;
  assign borrow_nxt = (~x & y) | (~(x ^ y) & z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        S_SHIFT: begin
          diff   <= {d, diff[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the sign bit differs from borrow out of it => signed overflow.
            ovf  <= z ^ borrow_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Complement of the team's ripple full adder: same operand widths and carry/borrow conventions, traded for area over latency.
- Sits beside the adder datapath; driven by a start/done handshake from the control unit.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the start edge.
- b  input  WIDTH  subtrahend; sampled on the start edge.
- bin  input  1  borrow-in; sampled on the start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle on.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (async, asserts immediately): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, borrow register=0, operand shift registers=0.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE -> SHIFT on a clock edge with start=1:
  - latch a and b into shift registers; load borrow register with bin; counter=0.
  - diff and bout keep their previous values until overwritten.
- SHIFT, each edge:
  - cell inputs: x = a_sr[0], y = b_sr[0], z = borrow.
  - d = x^y^z; borrow_next = (~x & y) | (~(x^y) & z).
  - shift d into diff at the MSB end (diff >> 1, d into bit WIDTH-1).
  - shift a_sr and b_sr right by 1; counter increments.
  - on the edge processing bit WIDTH-1, go to DONE and write bout = borrow_next.
- DONE: done=1 for exactly one cycle; unconditional transition to IDLE on the next edge.
- busy=1 only while in SHIFT.
- Latency: the start edge is edge k. diff/bout are final after edge k+WIDTH. done is high between edges k+WIDTH and k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously restarts on the first IDLE edge after DONE.
- Input sampling and ignoring start:
  - start is ignored in SHIFT and DONE; no queuing, and the current operation is unaffected.
  - a, b and bin may change freely after the start edge.
- Result hold: diff/bout hold their values after done until the next operation's first SHIFT edge begins overwriting diff.
- Reset mid-operation: abort immediately, all state returns to reset values, no done pulse.
- Boundaries:
  - a == b with bin=0: diff=0, bout=0.
  - a=0, b=0, bin=1: diff=all ones, bout=1.
  - a=all ones, b=0, bin=0: diff=a, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), updated on the same edge as bout.
  - ovf = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1), i.e. two's-complement signed overflow.
  - ovf holds its value like diff.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=0101, b=0011, bin=0, start at edge k: busy high for 4 cycles; done pulses between edges k+4 and k+5; diff=0010, bout=0; ovf=0 when enabled.
- a=0011, b=0101, bin=0: diff=1110, bout=1; ovf=0.
- a=0000, b=0000, bin=1: diff=1111, bout=1. Then a=1000, b=0001, bin=0 with SERIAL_SUB_OVF_EN: diff=0111, bout=0, ovf=1.
- Start held high continuously with operands 0101/0011 then 1111/0001: results 0010 then 1110; done pulses exactly WIDTH+2 cycles apart; start pulses during SHIFT/DONE cause no extra done pulses and no result corruption.
- Assert rst for 1 cycle at edge k+2 of an operation: busy/done/diff/bout drop to 0 immediately, no done pulse; a following start with 0111-0010 gives diff=0101, bout=0.
- Randomised sweep, all 512 (a,b,bin) combinations at WIDTH=4: diff == (a-b-bin) mod 16 and bout == (a < b+bin) on every done.
